harvard_sequencer: RTL and testbench
====================================

# harvard_sequencer

Multi-cycle control FSM for the Harvard MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback by issuing per-stage enable strobes, including the `enable` of the decode stage. It waits on instruction-memory and data-memory handshakes, and stops the core when the PC commits to the halt address or a memory wait times out.

## Interface
Parameters:
- `HALT_ADDR`, default 32'h0000_0000: committing this PC value ends execution.
- `MEM_TIMEOUT`, default 255: maximum wait cycles in FETCH or MEM before a fault (1..255).

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-high. Forces state IDLE and all outputs to reset values.
- `clk_enable`, input, 1: global stall when 0.
- `instr_valid`, input, 1: instruction memory word valid this cycle.
- `mem_ready`, input, 1: data memory access complete this cycle.
- `mem_active`, input, 1: from the decode stage; the current instruction needs the MEM stage.
- `reg_active`, input, 1: from the decode stage; the current instruction writes a register.
- `pc_next`, input, 32: PC value that will be committed by `pc_en`.
- `fetch_req`, output, 1: level request to instruction memory.
- `decode_en`, output, 1: one-cycle strobe; drives the decode stage `enable`.
- `exec_en`, output, 1: one-cycle ALU/branch strobe.
- `mem_req`, output, 1: level request to data memory.
- `wb_en`, output, 1: register-file write strobe.
- `pc_en`, output, 1: PC update strobe.
- `active`, output, 1: core running.
- `fault`, output, 1: sticky; set on timeout.
- `state`, output, 3: current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Outputs are Moore: a function of the state register and latched flags only.
- Reset values: `state`=IDLE; all strobes and requests 0; `active`=1; `fault`=0.
- IDLE → FETCH unconditionally. No strobes are asserted in IDLE.
- FETCH: `fetch_req`=1. Goes to DECODE on `instr_valid`.
- DECODE: `decode_en`=1. Goes to EXEC.
- EXEC: `exec_en`=1. `mem_active` and `reg_active` are sampled into internal flags `m_f` and `r_f`. Next state is MEM if `mem_active`=1, otherwise WB.
- MEM: `mem_req`=1. Goes to WB on `mem_ready`.
- WB: `wb_en`=`r_f`; `pc_en`=1. Next state is HALT if `pc_next`==`HALT_ADDR`, otherwise FETCH.
- HALT: `active`=0; all strobes 0. Exits only on `reset`.
- Wait timer:
  - 8-bit counter, cleared on entry to FETCH or MEM; increments each enabled cycle spent waiting there.
  - If it reaches `MEM_TIMEOUT` without a handshake, the FSM goes to HALT and `fault`=1.
  - If the handshake arrives on the same cycle the count reaches `MEM_TIMEOUT`, the handshake wins and there is no fault.
- `clk_enable`=0:
  - State, flags and counter hold.
  - `decode_en`, `exec_en`, `wb_en` and `pc_en` are forced to 0.
  - `fetch_req` and `mem_req` stay asserted; a handshake arriving while stalled is ignored.
- `instr_valid` outside FETCH and `mem_ready` outside MEM are ignored.

## Timing
- Latency per instruction, counted as cycles with `clk_enable`=1:
  - Non-memory instruction: 1 + F + 3, where F is the number of FETCH wait cycles (F=0 if `instr_valid` arrives in the first FETCH cycle). Minimum 4.
  - Memory instruction: adds 1 + M, where M is the number of MEM wait cycles. Minimum 5.
- The first `fetch_req` is asserted in the second cycle after `reset` deasserts.
- Each strobe is high for exactly one enabled cycle per instruction.
- `reset` asserted mid-instruction: outputs return to reset values immediately (asynchronously) and the in-flight instruction is discarded.
- `fault` clears only on `reset`.

## Structure
- Shared package `harvard_pkg`: state enum and encodings, `HALT_ADDR` default, timer width constant.
- One sub-module, `harvard_wait_timer`: clear, enable, count and expired outputs; parameterised by `MEM_TIMEOUT`.

## Test plan
- **ALU instruction.** Reset, then `instr_valid`=1 in the first FETCH cycle, `mem_active`=0, `reg_active`=1, `pc_next`=32'h4.
  - `state` sequence is 0,1,2,3,5,1.
  - `wb_en` and `pc_en` are high together for one cycle.
- **Load.** `mem_active`=1, `reg_active`=1, `mem_ready` delayed 3 cycles.
  - 3 extra MEM cycles with `mem_req` held high.
  - Total instruction latency is 8 cycles.
- **Store.** `mem_active`=1, `reg_active`=0, `pc_next`=32'h0 at WB.
  - `wb_en` stays 0 and `pc_en`=1.
  - Next state is HALT with `active`=0; state holds there for 20 cycles.
- **Timeout.** `MEM_TIMEOUT`=4, `instr_valid` never asserted.
  - HALT is reached after 4 FETCH wait cycles with `fault`=1.
  - Repeat with `instr_valid` on the 4th wait cycle: DECODE follows and `fault`=0.
- **Stall.** `clk_enable`=0 for 5 cycles while in EXEC.
  - `exec_en` is 0 throughout the stall.
  - `state` stays 3; on release, `exec_en` pulses once.
- **Reset mid-MEM.** Assert `reset` asynchronously between edges.
  - `mem_req` drops immediately and `state`=0.
  - A normal fetch restarts 2 cycles after release.

Source files
------------

// File: rtl/harvard_pkg.sv
// Shared types and constants for the Harvard core sequencer.
package harvard_pkg;

   localparam int          TMR_W         = 8;
   localparam logic [31:0] HALT_ADDR_DEF = 32'h0000_0000;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   // FETCH and MEM are the only states that wait on a memory handshake.
   function automatic logic is_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM);
   endfunction

endpackage

// File: rtl/harvard_sequencer_if.sv
// Handshake and strobe bundle between the sequencer and the core datapath.
interface harvard_sequencer_if;

   logic        clk_enable;
   logic        instr_valid;
   logic        mem_ready;
   logic        mem_active;
   logic        reg_active;
   logic [31:0] pc_next;

   logic        fetch_req;
   logic        decode_en;
   logic        exec_en;
   logic        mem_req;
   logic        wb_en;
   logic        pc_en;
   logic        active;
   logic        fault;
   logic [2:0]  state;

   modport master (
      input  clk_enable, instr_valid, mem_ready, mem_active, reg_active, pc_next,
      output fetch_req, decode_en, exec_en, mem_req, wb_en, pc_en, active, fault, state
   );

   modport slave (
      output clk_enable, instr_valid, mem_ready, mem_active, reg_active, pc_next,
      input  fetch_req, decode_en, exec_en, mem_req, wb_en, pc_en, active, fault, state
   );

endinterface

// File: rtl/harvard_wait_timer.sv
// Wait-cycle counter for the FETCH/MEM handshakes.
// expired flags the cycle on which one more unanswered wait would reach MEM_TIMEOUT.
module harvard_wait_timer
   import harvard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [TMR_W-1:0] count,
   output logic             expired
);

   localparam logic [TMR_W-1:0] LAST_WAIT = TMR_W'(MEM_TIMEOUT - 1);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   // Clear has priority; otherwise count one unanswered wait cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count   = cnt_q;
   assign expired = (cnt_q == LAST_WAIT);

endmodule

// File: rtl/harvard_sequencer.sv
// Multi-cycle instruction sequencer for the Harvard MIPS core.
//
// state  | meaning
// IDLE   | one cycle after reset before the first fetch
// FETCH  | fetch_req held until instr_valid (or wait timeout)
// DECODE | decode_en strobe
// EXEC   | exec_en strobe, latch mem/reg needs of the instruction
// MEM    | mem_req held until mem_ready (or wait timeout)
// WB     | pc_en strobe, wb_en if the instruction writes a register
// HALT   | core stopped; left only through reset
module harvard_sequencer
   import harvard_pkg::*;
#(
   parameter logic [31:0] HALT_ADDR   = HALT_ADDR_DEF,
   parameter int          MEM_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   harvard_sequencer_if.master  bus
);

   state_t           state_q, state_d;
   logic             m_f_q, m_f_d;
   logic             r_f_q, r_f_d;
   logic             fault_q, fault_d;

   logic             handshake;
   logic             tmr_clr;
   logic             tmr_en;
   logic             tmr_expired;
   logic [TMR_W-1:0] tmr_count;
   logic             unused_tmr_count;

   // The count itself is only of interest when probing the timer.
   assign unused_tmr_count = ^tmr_count;

   // Handshake qualification and timer control; handshakes outside their state are ignored.
   always_comb begin
      handshake = ((state_q == S_FETCH) && bus.instr_valid) ||
                  ((state_q == S_MEM)   && bus.mem_ready);
      tmr_clr   = !is_wait_state(state_q);
      tmr_en    = bus.clk_enable && is_wait_state(state_q) && !handshake;
   end

   harvard_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .count   (tmr_count),
      .expired (tmr_expired)
   );

   // Next-state and flag logic; everything holds while the core is stalled.
   always_comb begin
      state_d = state_q;
      m_f_d   = m_f_q;
      r_f_d   = r_f_q;
      fault_d = fault_q;
      if (bus.clk_enable) begin
         case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
               if (handshake) begin
                  state_d = S_DECODE;
               end else if (tmr_expired) begin
                  state_d = S_HALT;
                  fault_d = 1'b1;
               end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
               m_f_d   = bus.mem_active;
               r_f_d   = bus.reg_active;
               state_d = bus.mem_active ? S_MEM : S_WB;
            end
            S_MEM: begin
               if (handshake) begin
                  state_d = S_WB;
               end else if (tmr_expired) begin
                  state_d = S_HALT;
                  fault_d = 1'b1;
               end
            end
            S_WB:     state_d = (bus.pc_next == HALT_ADDR) ? S_HALT : S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // State and latched-flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         m_f_q   <= 1'b0;
         r_f_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         m_f_q   <= m_f_d;
         r_f_q   <= r_f_d;
         fault_q <= fault_d;
      end
   end

   // Moore outputs; one-cycle strobes are suppressed during a stall, level requests are not.
   always_comb begin
      bus.fetch_req = (state_q == S_FETCH);
      bus.decode_en = bus.clk_enable && (state_q == S_DECODE);
      bus.exec_en   = bus.clk_enable && (state_q == S_EXEC);
      bus.mem_req   = (state_q == S_MEM) && m_f_q;
      bus.wb_en     = bus.clk_enable && (state_q == S_WB) && r_f_q;
      bus.pc_en     = bus.clk_enable && (state_q == S_WB);
      bus.active    = (state_q != S_HALT);
      bus.fault     = fault_q;
      bus.state     = state_q;
   end

endmodule

// File: tb/tb_harvard_sequencer.sv
// Directed bench for harvard_sequencer: each stimulus cycle pushes the expected
// output snapshot; an independent monitor pops and compares on the falling edge.
module tb_harvard_sequencer;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   logic clk;
   logic reset;

   harvard_sequencer_if sif ();

   harvard_sequencer #(
      .MEM_TIMEOUT (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tot = 0;
   int          n_bad = 0;
   int          n_cyc = 0;
   logic        mon_en = 1'b0;
   logic [10:0] exp_q[$];

   // Expected snapshot {state, fetch_req, decode_en, exec_en, mem_req, wb_en, pc_en, active, fault}.
   function automatic logic [10:0] exp_v(input logic [2:0] st, input logic en,
                                         input logic r, input logic flt);
      return {st, st == S_FETCH, en && (st == S_DECODE), en && (st == S_EXEC),
              st == S_MEM, en && r && (st == S_WB), en && (st == S_WB),
              st != S_HALT, flt};
   endfunction

   // Drive one cycle of inputs and queue what the DUT should show during it.
   task automatic cy(input logic en, input logic iv, input logic mr, input logic ma,
                     input logic ra, input logic [31:0] pc, input logic [2:0] st,
                     input logic r, input logic flt);
      sif.clk_enable  = en;
      sif.instr_valid = iv;
      sif.mem_ready   = mr;
      sif.mem_active  = ma;
      sif.reg_active  = ra;
      sif.pc_next     = pc;
      exp_q.push_back(exp_v(st, en, r, flt));
      mon_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_now(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Two cycles in reset, then the first post-reset cycle (IDLE).
   task automatic do_reset();
      reset = 1'b1;
      cy(1, 0, 0, 0, 0, 32'h0, S_IDLE, 0, 0);
      cy(1, 0, 0, 0, 0, 32'h0, S_IDLE, 0, 0);
      reset = 1'b0;
      cy(1, 0, 0, 0, 0, 32'h0, S_IDLE, 0, 0);
   endtask

   // Monitor: one comparison per cycle while tracing is on.
   initial begin
      logic [10:0] act;
      logic [10:0] e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            n_cyc++;
            act = {sif.state, sif.fetch_req, sif.decode_en, sif.exec_en, sif.mem_req,
                   sif.wb_en, sif.pc_en, sif.active, sif.fault};
            n_tot++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL trace_underflow cyc=%0d got=%03h exp=none", n_cyc, act);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  n_bad++;
                  $display("FAIL trace cyc=%0d got=%03h (st=%0d) exp=%03h (st=%0d)",
                           n_cyc, act, act[10:8], e, e[10:8]);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset           = 1'b1;
      sif.clk_enable  = 1'b1;
      sif.instr_valid = 1'b0;
      sif.mem_ready   = 1'b0;
      sif.mem_active  = 1'b0;
      sif.reg_active  = 1'b0;
      sif.pc_next     = 32'h0;
      @(posedge clk);
      #1;

      // ALU instruction: 0,1,2,3,5,1 with wb_en and pc_en together.
      do_reset();
      cy(1, 1, 0, 0, 0, 32'h0, S_FETCH,  0, 0);
      cy(1, 0, 0, 0, 0, 32'h0, S_DECODE, 0, 0);
      cy(1, 0, 0, 0, 1, 32'h0, S_EXEC,   0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_WB,     1, 0);

      // Load: mem_ready after 3 MEM waits (lands on the timeout boundary, handshake wins).
      cy(1, 1, 0, 0, 0, 32'h0, S_FETCH,  0, 0);
      cy(1, 0, 0, 0, 0, 32'h0, S_DECODE, 0, 0);
      cy(1, 0, 0, 1, 1, 32'h0, S_EXEC,   0, 0);
      cy(1, 0, 0, 0, 0, 32'h0, S_MEM,    0, 0);
      cy(1, 0, 0, 0, 0, 32'h0, S_MEM,    0, 0);
      cy(1, 0, 0, 0, 0, 32'h0, S_MEM,    0, 0);
      cy(1, 0, 1, 0, 0, 32'h0, S_MEM,    0, 0);
      cy(1, 0, 0, 0, 0, 32'h8, S_WB,     1, 0);

      // Store to halt address: no wb_en, pc_en, then HALT for 20 cycles ignoring handshakes.
      cy(1, 1, 0, 0, 0, 32'h0, S_FETCH,  0, 0);
      cy(1, 0, 0, 0, 0, 32'h0, S_DECODE, 0, 0);
      cy(1, 0, 0, 1, 0, 32'h0, S_EXEC,   0, 0);
      cy(1, 0, 1, 0, 0, 32'h0, S_MEM,    0, 0);
      cy(1, 0, 0, 0, 1, 32'h0, S_WB,     0, 0);
      for (int i = 0; i < 20; i++) cy(1, 1, 1, 1, 1, 32'h0, S_HALT, 0, 0);

      // FETCH timeout: 4 enabled waits (one stalled cycle in between does not count).
      do_reset();
      cy(1, 0, 0, 0, 0, 32'h4, S_FETCH, 0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_FETCH, 0, 0);
      cy(0, 0, 0, 0, 0, 32'h4, S_FETCH, 0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_FETCH, 0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_FETCH, 0, 0);
      cy(1, 1, 0, 0, 0, 32'h4, S_HALT,  0, 1);
      cy(1, 1, 0, 0, 0, 32'h4, S_HALT,  0, 1);

      // Reset clears fault; instr_valid on the 4th wait cycle goes to DECODE.
      do_reset();
      cy(1, 0, 0, 0, 0, 32'h4, S_FETCH,  0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_FETCH,  0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_FETCH,  0, 0);
      cy(1, 1, 0, 0, 0, 32'h4, S_FETCH,  0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_DECODE, 0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_EXEC,   0, 0);
      cy(1, 0, 0, 0, 1, 32'h4, S_WB,     0, 0);

      // MEM timeout: 4 unanswered MEM cycles fault into HALT.
      cy(1, 1, 0, 0, 0, 32'h4, S_FETCH,  0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_DECODE, 0, 0);
      cy(1, 0, 0, 1, 1, 32'h4, S_EXEC,   0, 0);
      for (int i = 0; i < 4; i++) cy(1, 0, 0, 0, 0, 32'h4, S_MEM, 0, 0);
      cy(1, 0, 1, 0, 0, 32'h4, S_HALT,   0, 1);

      // Stall: 5 cycles in EXEC with exec_en low, then a single exec_en pulse.
      do_reset();
      cy(1, 1, 0, 0, 0, 32'h4, S_FETCH,  0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_DECODE, 0, 0);
      for (int i = 0; i < 5; i++) cy(0, 0, 0, 1, 0, 32'h4, S_EXEC, 0, 0);
      cy(1, 0, 0, 0, 1, 32'h4, S_EXEC,   0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_WB,     1, 0);
      // Stalled FETCH ignores instr_valid; stalled WB holds its strobes.
      cy(0, 1, 0, 0, 0, 32'h4, S_FETCH,  0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_FETCH,  0, 0);
      cy(1, 1, 0, 0, 0, 32'h4, S_FETCH,  0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_DECODE, 0, 0);
      cy(1, 0, 0, 0, 1, 32'h4, S_EXEC,   0, 0);
      cy(0, 0, 0, 0, 0, 32'h0, S_WB,     1, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_WB,     1, 0);

      // Reset mid-MEM: outputs drop immediately, fetch resumes 2 cycles after release.
      cy(1, 1, 0, 0, 0, 32'h4, S_FETCH,  0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_DECODE, 0, 0);
      cy(1, 0, 0, 1, 1, 32'h4, S_EXEC,   0, 0);
      sif.mem_ready = 1'b0;
      exp_q.push_back(exp_v(S_MEM, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk_now("async_rst_state",   32'(sif.state),   32'(S_IDLE));
      chk_now("async_rst_mem_req", 32'(sif.mem_req), 32'h0);
      chk_now("async_rst_active",  32'(sif.active),  32'h1);
      @(posedge clk);
      #1;
      cy(1, 0, 0, 0, 0, 32'h4, S_IDLE,   0, 0);
      reset = 1'b0;
      cy(1, 0, 0, 0, 0, 32'h4, S_IDLE,   0, 0);
      cy(1, 1, 0, 0, 0, 32'h4, S_FETCH,  0, 0);
      cy(1, 0, 0, 0, 0, 32'h4, S_DECODE, 0, 0);

      mon_en = 1'b0;
      chk_now("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
